// File: rtl/vector_streamer_pkg.sv
// Shared types and helpers for the vector streamer family.
package vector_streamer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic [0:0] {
        S_IDLE,
        S_STREAM
    } state_e;

    // Ceiling log2 with a floor of one bit, so single-value counters still get a port.
    function automatic int unsigned calc_clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/vector_streamer_if.sv
// Output beat stream of the vector streamer: valid/ready with data, keep, index, last.
interface vector_streamer_if
    import vector_streamer_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_W      = 8
);
    logic                        m_valid;
    logic                        m_ready;
    logic [LANES*DATA_WIDTH-1:0] m_data;
    logic [LANES-1:0]            m_keep;
    logic [IDX_W-1:0]            m_index;
    logic                        m_last;

    modport master (output m_valid, m_data, m_keep, m_index, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_keep, m_index, m_last, output m_ready);

endinterface

// File: rtl/vector_streamer.sv
// Captures a full COUNT-element vector on start and streams it out LANES elements per beat.
module vector_streamer
    import vector_streamer_pkg::*;
#(
    parameter int COUNT      = 256,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [DATA_WIDTH*COUNT-1:0] vector_in,
    output logic                        busy,
    output logic                        done,
    vector_streamer_if.master           m
);

    localparam int unsigned BEATS     = (COUNT + LANES - 1) / LANES;
    localparam int unsigned BEAT_W    = calc_clog2(BEATS);
    localparam int unsigned IDX_W     = calc_clog2(COUNT);
    localparam int unsigned LANE_BITS = LANES * DATA_WIDTH;
    localparam int unsigned BUF_W     = BEATS * LANE_BITS;

    if (COUNT <= 0 || LANES <= 0 || LANES > COUNT) begin : g_bad_params
        $error("vector_streamer: invalid COUNT=%0d LANES=%0d", COUNT, LANES);
    end

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic                  m_valid_q, m_valid_d;
    logic [LANE_BITS-1:0]  m_data_q, m_data_d;
    logic [LANES-1:0]      m_keep_q, m_keep_d;
    logic [IDX_W-1:0]      m_index_q, m_index_d;
    logic                  m_last_q, m_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  load;
    logic [BEAT_W-1:0]     sel_beat;
    logic [BUF_W-1:0]      src;
    int unsigned           lane_base;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        buf_d     = buf_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        sel_beat  = '0;
        src       = buf_q;
        lane_base = 0;

        case (state_q)
            S_IDLE: begin
                // Beat 0 comes straight from the input so it is on the outputs one cycle after start.
                if (start) begin
                    buf_d     = BUF_W'(vector_in);
                    src       = BUF_W'(vector_in);
                    load      = 1'b1;
                    beat_d    = '0;
                    state_d   = S_STREAM;
                    m_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    busy_d    = 1'b0;
                end else if (m.m_ready) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d   = S_IDLE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        beat_d   = beat_q + BEAT_W'(1);
                        sel_beat = beat_q + BEAT_W'(1);
                        load     = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            lane_base = 32'(sel_beat) * LANES;
            m_data_d  = src[lane_base*DATA_WIDTH +: LANE_BITS];
            m_index_d = IDX_W'(lane_base);
            m_last_d  = (sel_beat == BEAT_W'(BEATS - 1));
            for (int unsigned k = 0; k < LANES; k++) begin
                m_keep_d[k] = (lane_base + k) < COUNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            buf_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            buf_q     <= buf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_index_q <= m_index_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign m.m_valid = m_valid_q;
    assign m.m_data  = m_data_q;
    assign m.m_keep  = m_keep_q;
    assign m.m_index = m_index_q;
    assign m.m_last  = m_last_q;

endmodule

// File: tb/tb_vector_streamer.sv
// Scoreboard bench for vector_streamer: COUNT=5/LANES=2 and COUNT=4/LANES=4 instances.
module tb_vector_streamer;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  keep;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start5 = 1'b0, abort5 = 1'b0, busy5, done5;
    logic [79:0]  vec5 = '0;
    logic         start4 = 1'b0, abort4 = 1'b0, busy4, done4;
    logic [63:0]  vec4 = '0;

    vector_streamer_if #(.LANES(2), .DATA_WIDTH(16), .IDX_W(3)) if5 ();
    vector_streamer_if #(.LANES(4), .DATA_WIDTH(16), .IDX_W(2)) if4 ();

    vector_streamer #(.COUNT(5), .LANES(2), .DATA_WIDTH(16)) u5 (
        .clk(clk), .rst(rst), .start(start5), .abort(abort5), .vector_in(vec5),
        .busy(busy5), .done(done5), .m(if5.master)
    );
    vector_streamer #(.COUNT(4), .LANES(4), .DATA_WIDTH(16)) u4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .vector_in(vec4),
        .busy(busy4), .done(done4), .m(if4.master)
    );

    localparam logic [79:0] VEC_A = 80'h0055_0044_0033_0022_0011;
    localparam logic [79:0] VEC_B = 80'h0505_0404_0303_0202_0101;

    int    total = 0;
    int    bad   = 0;
    int    done_seen5 = 0, done_seen4 = 0;
    int    exp_done5 = 0, exp_done4 = 0;
    beat_t q5[$];
    beat_t q4[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic [3:0] k,
                                 input logic [2:0] i, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.idx = i; b.last = l;
        return b;
    endfunction

    task automatic push_a(input int n);
        if (n > 0) q5.push_back(mk(64'h0022_0011, 4'b11, 3'd0, 1'b0));
        if (n > 1) q5.push_back(mk(64'h0044_0033, 4'b11, 3'd2, 1'b0));
        if (n > 2) q5.push_back(mk(64'h0000_0055, 4'b01, 3'd4, 1'b1));
    endtask

    task automatic push_b(input int n);
        if (n > 0) q5.push_back(mk(64'h0202_0101, 4'b11, 3'd0, 1'b0));
        if (n > 1) q5.push_back(mk(64'h0404_0303, 4'b11, 3'd2, 1'b0));
        if (n > 2) q5.push_back(mk(64'h0000_0505, 4'b01, 3'd4, 1'b1));
    endtask

    // Monitors: pop expected beat on every accepted transfer, away from the rising edge.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && if5.m_valid && if5.m_ready) begin
            if (q5.size() == 0) begin
                chk("u5_unexpected_beat", 64'(if5.m_index), 64'hFF);
            end else begin
                e = q5.pop_front();
                chk("u5_data",  64'(if5.m_data),  e.data);
                chk("u5_keep",  64'(if5.m_keep),  64'(e.keep));
                chk("u5_index", 64'(if5.m_index), 64'(e.idx));
                chk("u5_last",  64'(if5.m_last),  64'(e.last));
            end
        end
        if (!rst && if4.m_valid && if4.m_ready) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_beat", 64'(if4.m_index), 64'hFF);
            end else begin
                e = q4.pop_front();
                chk("u4_data",  64'(if4.m_data),  e.data);
                chk("u4_keep",  64'(if4.m_keep),  64'(e.keep));
                chk("u4_index", 64'(if4.m_index), 64'(e.idx));
                chk("u4_last",  64'(if4.m_last),  64'(e.last));
            end
        end
        if (done5) done_seen5++;
        if (done4) done_seen4++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done5(input int exp_cyc, input int exp_busy);
        int cyc;
        int busy_cnt;
        cyc = 0;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done5) break;
            if (busy5) busy_cnt++;
            tick();
            cyc++;
        end
        chk("u5_done_reached", 64'(done5), 64'd1);
        chk("u5_done_latency", 64'(cyc), 64'(exp_cyc));
        chk("u5_busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        chk("u5_busy_at_done", 64'(busy5), 64'd0);
        chk("u5_valid_at_done", 64'(if5.m_valid), 64'd0);
        chk("u5_last_at_done", 64'(if5.m_last), 64'd0);
    endtask

    initial begin
        if5.m_ready = 1'b0;
        if4.m_ready = 1'b0;
        repeat (2) tick();
        chk("rst_busy5",  64'(busy5), 64'd0);
        chk("rst_done5",  64'(done5), 64'd0);
        chk("rst_valid5", 64'(if5.m_valid), 64'd0);
        chk("rst_data5",  64'(if5.m_data), 64'd0);
        chk("rst_keep5",  64'(if5.m_keep), 64'd0);
        chk("rst_index5", 64'(if5.m_index), 64'd0);
        chk("rst_last5",  64'(if5.m_last), 64'd0);
        chk("rst_valid4", 64'(if4.m_valid), 64'd0);
        rst = 1'b0;
        tick();

        // 1: full-throughput stream; also m_ready while idle is harmless
        if5.m_ready = 1'b1;
        tick();
        chk("t1_idle_valid", 64'(if5.m_valid), 64'd0);
        vec5 = VEC_A; push_a(3); exp_done5++;
        start5 = 1'b1; tick(); start5 = 1'b0;
        chk("t1_valid_latency", 64'(if5.m_valid), 64'd1);
        chk("t1_busy_latency", 64'(busy5), 64'd1);
        run_to_done5(3, 3);
        tick();
        chk("t1_done_one_cycle", 64'(done5), 64'd0);

        // 2: stall on beat 1 for three cycles
        push_a(3); exp_done5++;
        start5 = 1'b1; tick(); start5 = 1'b0;
        tick();
        if5.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_data", 64'(if5.m_data), 64'h0044_0033);
            chk("t2_hold_index", 64'(if5.m_index), 64'd2);
            chk("t2_hold_valid", 64'(if5.m_valid), 64'd1);
        end
        if5.m_ready = 1'b1;
        run_to_done5(2, 2);
        tick();

        // 3: start ignored mid-stream, accepted in the done cycle
        push_a(3); push_b(3); exp_done5 += 2;
        start5 = 1'b1; tick(); start5 = 1'b0;
        tick();
        vec5 = VEC_B; start5 = 1'b1; tick(); start5 = 1'b0;
        chk("t3_ignored_start", 64'(if5.m_data), 64'h0000_0055);
        tick();
        chk("t3_done_cycle", 64'(done5), 64'd1);
        start5 = 1'b1; tick(); start5 = 1'b0;
        chk("t3_restart_data", 64'(if5.m_data), 64'h0202_0101);
        chk("t3_restart_busy", 64'(busy5), 64'd1);
        run_to_done5(3, 3);
        tick();

        // 4a: abort while beat 1 stalled
        push_b(1);
        start5 = 1'b1; tick(); start5 = 1'b0;
        tick();
        if5.m_ready = 1'b0; abort5 = 1'b1; tick(); abort5 = 1'b0;
        chk("t4_abort_valid", 64'(if5.m_valid), 64'd0);
        chk("t4_abort_busy", 64'(busy5), 64'd0);
        chk("t4_abort_done", 64'(done5), 64'd0);
        tick();
        chk("t4_abort_no_done", 64'(done5), 64'd0);
        // 4b: abort together with a handshake on beat 0
        vec5 = VEC_A; push_a(1);
        start5 = 1'b1; tick(); start5 = 1'b0;
        if5.m_ready = 1'b1; abort5 = 1'b1; tick(); abort5 = 1'b0;
        chk("t4b_abort_valid", 64'(if5.m_valid), 64'd0);
        // 4c: start beats abort in idle, stream begins fresh from beat 0
        push_a(3); exp_done5++;
        start5 = 1'b1; abort5 = 1'b1; tick(); start5 = 1'b0; abort5 = 1'b0;
        chk("t4c_valid", 64'(if5.m_valid), 64'd1);
        chk("t4c_index", 64'(if5.m_index), 64'd0);
        run_to_done5(3, 3);
        tick();

        // 5: asynchronous reset in the middle of beat 1
        push_a(1);
        start5 = 1'b1; tick(); start5 = 1'b0;
        tick();
        if5.m_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(if5.m_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy5), 64'd0);
        chk("t5_rst_data", 64'(if5.m_data), 64'd0);
        chk("t5_rst_keep", 64'(if5.m_keep), 64'd0);
        chk("t5_rst_index", 64'(if5.m_index), 64'd0);
        chk("t5_rst_last", 64'(if5.m_last), 64'd0);
        tick();
        rst = 1'b0;
        if5.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_done", 64'(done5), 64'd0);
            chk("t5_no_valid", 64'(if5.m_valid), 64'd0);
        end

        // 6: COUNT == LANES gives a single full beat
        vec4 = 64'h0044_0033_0022_0011;
        q4.push_back(mk(64'h0044_0033_0022_0011, 4'b1111, 3'd0, 1'b1)); exp_done4++;
        if4.m_ready = 1'b1;
        start4 = 1'b1; tick(); start4 = 1'b0;
        chk("t6_last", 64'(if4.m_last), 64'd1);
        chk("t6_keep", 64'(if4.m_keep), 64'hF);
        tick();
        chk("t6_done", 64'(done4), 64'd1);
        chk("t6_valid_after", 64'(if4.m_valid), 64'd0);
        tick();

        chk("q5_drained", 64'(q5.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);
        chk("done5_count", 64'(done_seen5), 64'(exp_done5));
        chk("done4_count", 64'(done_seen4), 64'(exp_done4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
